muldiv_unit: RTL

// - Iterative multiply/divide unit fed from the execute stage (MULT/MULTU/DIV/DIVU); owns the HI/LO registers.
// - Accepts one operation on a qualified enable, runs 32 iterations, writes HI/LO, then serves MFHI/MFLO reads.
// - Raises a stall request to the hazard unit while a HI/LO read is pending and the unit is still busy.

---
 rtl/muldiv_unit_pkg.sv | 19 +
 rtl/muldiv_datapath.sv | 100 ++++++++++
 rtl/muldiv_unit.sv | 101 ++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit: FSM state encoding,
// default widths and the divide-by-zero LO value.
package muldiv_unit_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = 5;

  // IDLE waits for a start, CALC runs one iteration per cycle, FIX applies
  // signs and commits HI/LO.
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2
  } mdState_e;

  // LO after a divide by zero (the restoring loop naturally produces all ones).
  localparam logic [MD_WIDTH-1:0] MD_DIVZ_LO = '1;

endpackage

// File: rtl/muldiv_datapath.sv
// Arithmetic core of the multiply/divide unit: operand magnitudes, the
// shift-add product accumulator, the restoring divider and sign fix-up.
// Sequencing (when to load, when to step) comes from the top-level FSM.
module muldiv_datapath
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             divSel,
  input  logic             signedOp,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic [WIDTH-1:0] hiResult,
  output logic [WIDTH-1:0] loResult
);

  // acc holds {product upper, multiplier} for multiply and
  // {unused, dividend/quotient} for divide; quotient bits shift in at the LSB.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   magB;
  logic [WIDTH-1:0]   rem;
  logic               isDiv;
  logic               resNeg;
  logic               remNeg;
  logic               divZero;

  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magBIn;
  logic [WIDTH:0]     addend;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]   remainder;

  assign magA   = (signedOp && opA[WIDTH-1]) ? (~opA + 1'b1) : opA;
  assign magBIn = (signedOp && opB[WIDTH-1]) ? (~opB + 1'b1) : opB;

  // Multiply step: add multiplicand into the upper half when the current
  // multiplier LSB is set, then shift the whole accumulator right.
  assign addend = acc[0] ? {1'b0, magB} : '0;
  assign sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + addend;

  // Divide step: bring in the next dividend bit and try subtracting the
  // divisor; the extra top bit of trial is the borrow.
  assign shifted = {rem, acc[WIDTH-1]};
  assign trial   = shifted - {1'b0, magB};

  // Operand latch on start, then one multiply or divide iteration per step.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc     <= '0;
      magB    <= '0;
      rem     <= '0;
      isDiv   <= 1'b0;
      resNeg  <= 1'b0;
      remNeg  <= 1'b0;
      divZero <= 1'b0;
    end else if (load) begin
      acc     <= {{WIDTH{1'b0}}, magA};
      magB    <= magBIn;
      rem     <= '0;
      isDiv   <= divSel;
      resNeg  <= signedOp && (opA[WIDTH-1] ^ opB[WIDTH-1]);
      remNeg  <= signedOp && opA[WIDTH-1];
      divZero <= divSel && (opB == '0);
    end else if (step) begin
      if (!isDiv) begin
        acc <= {sum, acc[WIDTH-1:1]};
      end else if (!trial[WIDTH]) begin
        rem             <= trial[WIDTH-1:0];
        acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], 1'b1};
      end else begin
        rem             <= shifted[WIDTH-1:0];
        acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Sign fix-up and HI/LO selection; a zero divisor forces LO while HI keeps
  // the dividend (its magnitude re-signed gives back the original value).
  always_comb begin
    product   = resNeg ? (~acc + 1'b1) : acc;
    quotient  = resNeg ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    remainder = remNeg ? (~rem + 1'b1) : rem;
    if (isDiv) begin
      hiResult = remainder;
      loResult = divZero ? MD_DIVZ_LO : quotient;
    end else begin
      hiResult = product[2*WIDTH-1:WIDTH];
      loResult = product[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO. Control FSM, iteration
// counter, HI/LO registers and the read port live here; arithmetic is in
// muldiv_datapath.
// Handshake: muldiv_en is a single-cycle start pulse honoured only when idle
// (busy==0); busy stays high until the result is committed, done pulses for
// one cycle when the new HI/LO becomes visible on hilo_out.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = MD_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             muldiv_en,
  input  logic             mul0_div1_sel,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hilo_rd,
  input  logic             hi0_lo1_sel,
  output logic [WIDTH-1:0] hilo_out,
  output logic             busy,
  output logic             done,
  output logic             muldiv_stall,
  output mdState_e         dbgState
);

  mdState_e         state;
  mdState_e         nextState;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hiReg;
  logic [WIDTH-1:0] loReg;
  logic [WIDTH-1:0] hiResult;
  logic [WIDTH-1:0] loResult;
  logic             start;
  logic             doneReg;

  assign start = (state == MD_IDLE) && muldiv_en;

  muldiv_datapath #(
    .WIDTH(WIDTH)
  ) uDatapath (
    .clk      (clk),
    .rst      (rst),
    .load     (start),
    .step     (state == MD_CALC),
    .divSel   (mul0_div1_sel),
    .signedOp (signed_op),
    .opA      (op_a),
    .opB      (op_b),
    .hiResult (hiResult),
    .loResult (loResult)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= MD_IDLE;
    else      state <= nextState;
  end

  // Next-state logic: starts are ignored outside IDLE.
  always_comb begin
    nextState = state;
    case (state)
      MD_IDLE: if (muldiv_en) nextState = MD_CALC;
      MD_CALC: if (cnt == '0) nextState = MD_FIX;
      MD_FIX:  nextState = MD_IDLE;
      default: nextState = MD_IDLE;
    endcase
  end

  // Iteration counter: loaded with all ones on start, counts down in CALC.
  always_ff @(posedge clk) begin
    if (!rst)                          cnt <= '0;
    else if (start)                    cnt <= '1;
    else if (state == MD_CALC && cnt != '0) cnt <= cnt - 1'b1;
  end

  // HI/LO commit in FIX and the one-cycle done pulse that follows it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hiReg   <= '0;
      loReg   <= '0;
      doneReg <= 1'b0;
    end else begin
      doneReg <= (state == MD_FIX);
      if (state == MD_FIX) begin
        hiReg <= hiResult;
        loReg <= loResult;
      end
    end
  end

  assign busy         = (state != MD_IDLE);
  assign done         = doneReg;
  assign muldiv_stall = hilo_rd && busy;
  assign hilo_out     = hi0_lo1_sel ? loReg : hiReg;
  assign dbgState     = state;

endmodule
